// File: rtl/proc_mem_io.sv
// Memory and I/O subsystem for the 16-bit processor: RAM, LEDR register,
// synchronized switch port and a ready/valid output FIFO, all behind a 1-cycle read.
module proc_mem_io #(
  parameter int RAM_AW     = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [15:0] fifo_data,
  output logic        fifo_valid,
  input  logic        fifo_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] SEL_RAM  = 4'h0;
  localparam logic [3:0] SEL_LEDR = 4'h1;
  localparam logic [3:0] SEL_SW   = 4'h3;
  localparam logic [3:0] SEL_FDAT = 4'h4;
  localparam logic [3:0] SEL_FSTS = 4'h5;

  logic [15:0] ram [2**RAM_AW];
  logic [15:0] fifo_mem [FIFO_DEPTH];

  logic [15:0] din_q, din_d;
  logic [9:0]  ledr_q, ledr_d;
  logic [9:0]  sw_meta_q, sw_meta_d;
  logic [9:0]  sw_sync_q, sw_sync_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic        ovf_q, ovf_d;

  logic [3:0]        sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       ram_rd;
  logic [7:0]        count8;
  logic              full, empty;
  logic              ram_we, push_req, push, pop, ovf_clr;
  logic              unused_addr;

  assign sel         = ADDR[15:12];
  assign ram_idx     = ADDR[RAM_AW-1:0];
  assign unused_addr = ^ADDR[11:RAM_AW];

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  assign ram_we   = W && (sel == SEL_RAM);
  assign push_req = W && (sel == SEL_FDAT);
  assign push     = push_req && !full;
  assign pop      = !empty && fifo_ready;
  assign ovf_clr  = W && (sel == SEL_FSTS);

  // Asynchronous array read feeding the DIN register gives old-data-on-write.
  assign ram_rd = ram[ram_idx];

  always_comb begin
    count8 = '0;
    count8[CW-1:0] = count_q;
  end

  always_comb begin
    din_d     = '0;
    ledr_d    = ledr_q;
    sw_meta_d = SW;
    sw_sync_d = sw_meta_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    unique case (sel)
      SEL_RAM:  din_d = ram_rd;
      SEL_LEDR: din_d = {6'b0, ledr_q};
      SEL_SW:   din_d = {6'b0, sw_sync_q};
      SEL_FSTS: din_d = {ovf_q, full, empty, 5'b0, count8};
      default:  din_d = '0;
    endcase

    if (W && (sel == SEL_LEDR)) ledr_d = DOUT[9:0];

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // A dropped push sets overflow even when a clear is not on the same edge.
    if (ovf_clr)                 ovf_d = 1'b0;
    else if (push_req && full)   ovf_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      din_q     <= '0;
      ledr_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      din_q     <= din_d;
      ledr_q    <= ledr_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge Clock) begin
    if (ram_we) ram[ram_idx] <= DOUT;
    if (push)   fifo_mem[wr_ptr_q] <= DOUT;
  end

  assign DIN        = din_q;
  assign LEDR       = ledr_q;
  assign fifo_valid = !empty;
  assign fifo_data  = fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_proc_mem_io.sv
// Directed bench for proc_mem_io: table-driven register/RAM vectors plus
// hand-written sequences for reset, switch sync and FIFO corner cases.
module tb_proc_mem_io;

  logic        Clock;
  logic        Resetn;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [15:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;

  int errors = 0;
  int checks = 0;

  proc_mem_io #(.RAM_AW(7), .FIFO_DEPTH(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
    .DIN(DIN), .SW(SW), .LEDR(LEDR), .fifo_data(fifo_data),
    .fifo_valid(fifo_valid), .fifo_ready(fifo_ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        w;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        chk;
    logic [15:0] exp_din;
    logic [9:0]  exp_led;
  } vec_t;

  vec_t tbl[15];
  logic [15:0] q[$];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; DOUT = d; W = 1'b1;
    cyc();
    W = 1'b0;
  endtask

  initial begin
    logic do_push, pop_m, push_m;
    logic [15:0] val;

    tbl[0]  = '{1'b1, 16'h0006, 16'h1234, 1'b0, 16'h0000, 10'h000};
    tbl[1]  = '{1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000, 10'h000};
    tbl[2]  = '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'hBEEF, 10'h000};
    tbl[3]  = '{1'b0, 16'h0006, 16'h0000, 1'b1, 16'h1234, 10'h000};
    tbl[4]  = '{1'b1, 16'h0006, 16'h5555, 1'b1, 16'h1234, 10'h000};
    tbl[5]  = '{1'b0, 16'h0006, 16'h0000, 1'b1, 16'h5555, 10'h000};
    tbl[6]  = '{1'b1, 16'h1000, 16'h03FF, 1'b1, 16'h0000, 10'h3FF};
    tbl[7]  = '{1'b0, 16'h1000, 16'h0000, 1'b1, 16'h03FF, 10'h3FF};
    tbl[8]  = '{1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000, 10'h3FF};
    tbl[9]  = '{1'b1, 16'h2000, 16'hFFFF, 1'b1, 16'h0000, 10'h3FF};
    tbl[10] = '{1'b0, 16'h5000, 16'h0000, 1'b1, 16'h2000, 10'h3FF};
    tbl[11] = '{1'b0, 16'h4000, 16'h0000, 1'b1, 16'h0000, 10'h3FF};
    tbl[12] = '{1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'h0000, 10'h3FF};
    tbl[13] = '{1'b0, 16'h0080, 16'h0000, 1'b1, 16'hA5A5, 10'h3FF};
    tbl[14] = '{1'b0, 16'h3000, 16'h0000, 1'b1, 16'h0000, 10'h3FF};

    Resetn = 1'b0; ADDR = '0; DOUT = '0; W = 1'b0; SW = '0; fifo_ready = 1'b0;
    #12;
    check("rst_din", DIN, 16'h0000);
    check("rst_ledr", {6'b0, LEDR}, 16'h0000);
    check("rst_valid", {15'b0, fifo_valid}, 16'h0000);
    Resetn = 1'b1;
    cyc();

    // Load some state, then assert reset mid-cycle and see it clear at once.
    wr(16'h1000, 16'h0155);
    wr(16'h4000, 16'h0077);
    ADDR = 16'h1000;
    cyc();
    check("pre_rst_din", DIN, 16'h0155);
    check("pre_rst_valid", {15'b0, fifo_valid}, 16'h0001);
    #3 Resetn = 1'b0;
    #1;
    check("async_rst_din", DIN, 16'h0000);
    check("async_rst_ledr", {6'b0, LEDR}, 16'h0000);
    check("async_rst_valid", {15'b0, fifo_valid}, 16'h0000);
    #2 Resetn = 1'b1;
    cyc();
    ADDR = 16'h5000;
    cyc();
    check("post_rst_status", DIN, 16'h2000);

    for (int i = 0; i < 15; i++) begin
      ADDR = tbl[i].addr; DOUT = tbl[i].dout; W = tbl[i].w;
      cyc();
      W = 1'b0;
      if (tbl[i].chk) check($sformatf("vec%0d_din", i), DIN, tbl[i].exp_din);
      check($sformatf("vec%0d_ledr", i), {6'b0, LEDR}, {6'b0, tbl[i].exp_led});
    end

    // Switch change needs two synchronizer edges plus the DIN register edge.
    ADDR = 16'h3000; SW = 10'h2A5;
    cyc();
    check("sw_edge1", DIN, 16'h0000);
    cyc();
    check("sw_edge2", DIN, 16'h0000);
    cyc();
    check("sw_edge3", DIN, 16'h02A5);

    // Fill to full, then overflow.
    fifo_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(16'h4000, 16'(i));
    ADDR = 16'h5000;
    cyc();
    check("status_ovf_full", DIN, 16'hC008);
    wr(16'h5000, 16'hFFFF);
    cyc();
    check("status_ovf_clr", DIN, 16'h4008);

    ADDR = 16'h0000; fifo_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d_valid", i), {15'b0, fifo_valid}, 16'h0001);
      check($sformatf("drain%0d_data", i), fifo_data, 16'(i));
      cyc();
    end
    check("drain_done_valid", {15'b0, fifo_valid}, 16'h0000);
    ADDR = 16'h5000;
    cyc();
    check("empty_ready_valid", {15'b0, fifo_valid}, 16'h0000);
    check("empty_status", DIN, 16'h2000);

    // Simultaneous push and pop at count 3.
    fifo_ready = 1'b0;
    wr(16'h4000, 16'h0011);
    wr(16'h4000, 16'h0012);
    wr(16'h4000, 16'h0013);
    fifo_ready = 1'b1;
    wr(16'h4000, 16'h0014);
    fifo_ready = 1'b0; ADDR = 16'h5000;
    cyc();
    check("pushpop_count", DIN, 16'h0003);
    fifo_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("pushpop_data%0d", i), fifo_data, 16'h0010 + 16'(i));
      cyc();
    end
    check("pushpop_empty", {15'b0, fifo_valid}, 16'h0000);

    // Mixed traffic to wrap the pointers, checked against a queue model.
    fifo_ready = 1'b0;
    q.delete();
    for (int i = 0; i < 20; i++) begin
      do_push = (i % 4) != 3;
      val = 16'h0100 + 16'(i);
      fifo_ready = (i >= 1);
      ADDR = 16'h4000; DOUT = val; W = do_push;
      pop_m  = (q.size() > 0) && fifo_ready;
      push_m = do_push && (q.size() < 8);
      cyc();
      W = 1'b0;
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(val);
      check($sformatf("wrap%0d_valid", i), {15'b0, fifo_valid}, {15'b0, q.size() != 0});
      if (q.size() != 0) check($sformatf("wrap%0d_data", i), fifo_data, q[0]);
    end
    ADDR = 16'h0000; fifo_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      check($sformatf("wrap_drain%0d", i), fifo_data, q[0]);
      void'(q.pop_front());
      cyc();
    end
    check("wrap_end_valid", {15'b0, fifo_valid}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
